// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI3 slave fronting a single-port synchronous SRAM
// One read or write transaction at a time; FIXED/INCR bursts up to 16 beats.
module axi_sram_responder #(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t            state_q, state_d;
    logic              prio_wr_q, prio_wr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [1:0]        resp_q, resp_d;
    logic              wr_err_q, wr_err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fresh_q, fresh_d;
    logic              resp_ok;
    logic              last_beat;
    logic [31:0]       next_addr;
    logic [31:0]       rd_now;

    function automatic logic [1:0] classify(input logic [31:0] a, input logic [7:0] l,
                                            input logic [2:0] s, input logic [1:0] b);
        if (a[31:ADDR_W+2] != '0) return 2'b11;
        if (s > 3'd2 || b == 2'b10 || l > 8'd15) return 2'b10;
        return 2'b00;
    endfunction

    assign resp_ok   = (resp_q == 2'b00);
    assign last_beat = (cnt_q == len_q);
    assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);

    // The SRAM output is only valid in the first RD_DATA cycle; it is captured
    // there so the beat stays stable for as long as the master stalls.
    assign rd_now  = resp_ok ? ram_rdata : 32'd0;
    assign rdata   = fresh_q ? rd_now : rdata_q;
    assign rdata_d = rdata;

    assign rvalid    = (state_q == RD_DATA);
    assign rlast     = rvalid && last_beat;
    assign rresp     = resp_q;
    assign rid       = id_q;
    assign wready    = (state_q == WR_DATA);
    assign bvalid    = (state_q == WR_RESP);
    assign bresp     = wr_err_q ? 2'b10 : resp_q;
    assign bid       = id_q;
    assign ram_addr  = addr_q[ADDR_W+1:2];
    assign ram_wdata = wdata;

    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        resp_d    = resp_q;
        wr_err_d  = wr_err_q;
        fresh_d   = 1'b0;
        arready   = 1'b0;
        awready   = 1'b0;
        ram_en    = 1'b0;
        ram_wen   = 4'b0000;
        case (state_q)
            IDLE: begin
                arready = !(awvalid && prio_wr_q);
                awready = !(arvalid && !prio_wr_q);
                if (arvalid && arready) begin
                    id_d      = arid;
                    addr_d    = araddr;
                    len_d     = arlen;
                    size_d    = arsize;
                    burst_d   = arburst;
                    cnt_d     = 8'd0;
                    resp_d    = classify(araddr, arlen, arsize, arburst);
                    prio_wr_d = 1'b1;
                    state_d   = RD_ISSUE;
                end else if (awvalid && awready) begin
                    id_d      = awid;
                    addr_d    = awaddr;
                    len_d     = awlen;
                    size_d    = awsize;
                    burst_d   = awburst;
                    cnt_d     = 8'd0;
                    resp_d    = classify(awaddr, awlen, awsize, awburst);
                    wr_err_d  = 1'b0;
                    prio_wr_d = 1'b0;
                    state_d   = WR_DATA;
                end
            end
            RD_ISSUE: begin
                ram_en  = resp_ok;
                fresh_d = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    ram_en  = resp_ok;
                    ram_wen = resp_ok ? wstrb : 4'b0000;
                    if ((wlast != last_beat) || (wid != id_q)) wr_err_d = 1'b1;
                    if (wlast || last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
            WR_RESP: begin
                if (bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            ram_en  = 1'b0;
            ram_wen = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            resp_q    <= '0;
            wr_err_q  <= 1'b0;
            rdata_q   <= '0;
            fresh_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            resp_q    <= resp_d;
            wr_err_q  <= wr_err_d;
            rdata_q   <= rdata_d;
            fresh_q   <= fresh_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - directed and randomized bench for axi_sram_responder
// Reference memory and burst address arithmetic are kept in the bench.
module tb_axi_sram_responder;

    localparam int ADDR_W = 16;
    localparam int ID_W   = 4;

    logic              clk;
    logic              rst;
    logic [ID_W-1:0]   arid, awid, wid, rid, bid;
    logic [31:0]       araddr, awaddr, rdata, wdata;
    logic [7:0]        arlen, awlen;
    logic [2:0]        arsize, awsize;
    logic [1:0]        arburst, awburst, rresp, bresp;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready;
    logic              bvalid, bready;
    logic [3:0]        wstrb, ram_wen;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    int nerr = 0;
    int nchk = 0;

    logic [31:0] mem     [0:(1<<ADDR_W)-1];
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
    bit          init_done;
    logic [31:0] mw;
    logic [19:0] acc_q[$];
    logic [19:0] exp_acc[$];

    axi_sram_responder #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] seed_word(input int i);
        return 32'(i * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // SRAM model with 1-cycle read latency; also logs every enabled access.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= seed_word(i);
            mem[4] <= 32'hDEAD_BEEF;
            init_done <= 1'b1;
        end else if (ram_en) begin
            acc_q.push_back({ram_wen, ram_addr});
            if (ram_wen == 4'b0000) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                mw = mem[ram_addr];
                for (int b = 0; b < 4; b++)
                    if (ram_wen[b]) mw[8*b +: 8] = ram_wdata[8*b +: 8];
                mem[ram_addr] <= mw;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [1:0] classify(input logic [31:0] a, input logic [7:0] l,
                                            input logic [2:0] s, input logic [1:0] b);
        if ((a >> (ADDR_W + 2)) != 0) return 2'b11;
        if (s > 2 || b == 2'b10 || l > 15) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] advance(input logic [31:0] a, input logic [2:0] s,
                                            input logic [1:0] b);
        return (b == 2'b00) ? a : a + (32'd1 << s);
    endfunction

    task automatic check_acc();
        check("acc_count", 32'(acc_q.size()), 32'(exp_acc.size()));
        for (int i = 0; i < exp_acc.size() && i < acc_q.size(); i++)
            check("acc_entry", 32'(acc_q[i]), 32'(exp_acc[i]));
    endtask

    task automatic rd_txn(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit stall);
        logic [1:0]  er;
        logic [31:0] a, exp_d;
        bit          done;
        er = classify(addr, len, size, burst);
        exp_acc.delete();
        acc_q.delete();
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            done = arready;
            step();
        end
        arvalid = 1'b0;
        check("ar_accept", 32'(done), 32'd1);
        a = addr;
        for (int beat = 0; beat <= int'(len); beat++) begin
            exp_d = (er == 2'b00) ? ref_mem[a[ADDR_W+1:2]] : 32'd0;
            if (er == 2'b00) exp_acc.push_back({4'b0000, a[ADDR_W+1:2]});
            done = 1'b0;
            for (int n = 0; n < 40 && !done; n++) begin
                rready = (stall && n < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (rvalid) begin
                    check("rdata", rdata, exp_d);
                    check("rresp", 32'(rresp), 32'(er));
                    check("rlast", 32'(rlast), 32'(beat == int'(len)));
                    if (rready) begin
                        check("rid", 32'(rid), 32'(id));
                        done = 1'b1;
                    end
                end
                step();
            end
            rready = 1'b0;
            check("r_beat", 32'(done), 32'd1);
            a = advance(a, size, burst);
        end
        check_acc();
    endtask

    task automatic wr_txn(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit gaps,
                          input int early, input bit bad_id);
        logic [1:0]  er, exp_b;
        logic [31:0] a, d, w;
        logic [3:0]  s;
        bit          done, fin;
        er = classify(addr, len, size, burst);
        exp_b = er;
        exp_acc.delete();
        acc_q.delete();
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            done = awready;
            step();
        end
        awvalid = 1'b0;
        check("aw_accept", 32'(done), 32'd1);
        a = addr;
        fin = 1'b0;
        for (int beat = 0; beat <= int'(len) && !fin; beat++) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            wdata = d;
            wstrb = s;
            wid = bad_id ? (id ^ 4'h1) : id;
            wlast = (beat == int'(len)) || (beat == early);
            if (bad_id || (wlast != (beat == int'(len)))) exp_b = 2'b10;
            done = 1'b0;
            for (int n = 0; n < 20 && !done; n++) begin
                wvalid = (gaps && n < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (wvalid && wready) begin
                    check("w_ram_en", 32'(ram_en), 32'(er == 2'b00));
                    done = 1'b1;
                end
                step();
            end
            wvalid = 1'b0;
            check("w_beat", 32'(done), 32'd1);
            if (er == 2'b00) begin
                w = ref_mem[a[ADDR_W+1:2]];
                for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
                ref_mem[a[ADDR_W+1:2]] = w;
                exp_acc.push_back({s, a[ADDR_W+1:2]});
            end
            fin = wlast;
            a = advance(a, size, burst);
        end
        wlast = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            bready = (n < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bvalid) begin
                check("bresp", 32'(bresp), 32'(exp_b));
                check("bid", 32'(bid), 32'(id));
                done = bready;
            end
            step();
        end
        bready = 1'b0;
        check("b_done", 32'(done), 32'd1);
        check_acc();
    endtask

    initial begin
        logic [31:0] t_addr, t_d;
        logic [7:0]  t_len;
        logic [2:0]  t_size;
        logic [1:0]  t_burst;
        int          e, ar_t, aw_t;
        bit          hs_ar, hs_aw, hs_w, got_r, got_b;

        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = seed_word(i);
        ref_mem[4] = 32'hDEAD_BEEF;

        repeat (3) step();
        #1;
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_wen", 32'(ram_wen), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        rst = 1'b0;
        step();
        #1;
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_awready", 32'(awready), 32'd1);

        // Simultaneous AR/AW straight after reset: read must win, then write.
        arid = 4'h6; araddr = 32'h200; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'h7; awaddr = 32'h204; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        t_d = $urandom;
        wid = 4'h7; wdata = t_d; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        rready = 1'b1; bready = 1'b1;
        ar_t = -1; aw_t = -1; got_r = 1'b0; got_b = 1'b0;
        for (int t = 0; t < 40 && !got_b; t++) begin
            #1;
            if (arvalid && awvalid) check("both_ready", 32'(arready && awready), 32'd0);
            hs_ar = arvalid && arready;
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            if (hs_ar) ar_t = t;
            if (hs_aw) aw_t = t;
            if (rvalid) begin
                check("sim_rdata", rdata, ref_mem[32'h80]);
                check("sim_rid", 32'(rid), 32'h6);
                got_r = 1'b1;
            end
            if (bvalid) begin
                check("sim_bresp", 32'(bresp), 32'd0);
                check("sim_bid", 32'(bid), 32'h7);
                got_b = 1'b1;
            end
            step();
            if (hs_ar) arvalid = 1'b0;
            if (hs_aw) awvalid = 1'b0;
            if (hs_w) begin
                wvalid = 1'b0;
                wlast = 1'b0;
                ref_mem[32'h81] = t_d;
            end
        end
        rready = 1'b0; bready = 1'b0;
        check("sim_read_seen", 32'(got_r), 32'd1);
        check("sim_write_seen", 32'(got_b), 32'd1);
        check("sim_read_first", 32'(ar_t >= 0 && aw_t > ar_t), 32'd1);

        // FIXED single read with exact cycle timing.
        arid = 4'h3; araddr = 32'h10; arlen = 8'd0; arsize = 3'd2; arburst = 2'b00; arvalid = 1'b1;
        #1;
        check("t1_arready", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        #1;
        check("t1_ram_en", 32'(ram_en), 32'd1);
        check("t1_ram_addr", 32'(ram_addr), 32'd4);
        check("t1_ram_wen", 32'(ram_wen), 32'd0);
        step();
        rready = 1'b1;
        #1;
        check("t1_rvalid", 32'(rvalid), 32'd1);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_rlast", 32'(rlast), 32'd1);
        check("t1_rresp", 32'(rresp), 32'd0);
        check("t1_rid", 32'(rid), 32'h3);
        step();
        rready = 1'b0;

        // Byte write to byte address 5.
        awid = 4'h5; awaddr = 32'h5; awlen = 8'd0; awsize = 3'd0; awburst = 2'b01; awvalid = 1'b1;
        #1;
        check("t2_awready", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h0000_AB00; wstrb = 4'b0010; wlast = 1'b1; wid = 4'h5;
        #1;
        check("t2_wready", 32'(wready), 32'd1);
        check("t2_ram_en", 32'(ram_en), 32'd1);
        check("t2_ram_wen", 32'(ram_wen), 32'b0010);
        check("t2_ram_addr", 32'(ram_addr), 32'd1);
        check("t2_ram_wdata", ram_wdata, 32'h0000_AB00);
        step();
        wvalid = 1'b0; wlast = 1'b0;
        ref_mem[1][15:8] = 8'hAB;
        bready = 1'b1;
        #1;
        check("t2_bvalid", 32'(bvalid), 32'd1);
        check("t2_bresp", 32'(bresp), 32'd0);
        check("t2_bid", 32'(bid), 32'h5);
        step();
        bready = 1'b0;

        rd_txn(4'h0, 32'h4, 8'd0, 3'd2, 2'b00, 1'b0);
        rd_txn(4'h0, 32'h204, 8'd0, 3'd2, 2'b01, 1'b0);
        rd_txn(4'h1, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);
        wr_txn(4'h2, 32'h300, 8'd1, 3'd2, 2'b01, 1'b0, 0, 1'b0);
        rd_txn(4'h4, 32'h1000_0000, 8'd0, 3'd2, 2'b01, 1'b0);
        rd_txn(4'h8, 32'h40, 8'd16, 3'd2, 2'b01, 1'b0);
        wr_txn(4'h9, 32'h400, 8'd2, 3'd2, 2'b01, 1'b0, -1, 1'b1);

        // Reset one cycle after an AR handshake.
        arid = 4'hA; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        #1;
        check("t7_arready", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        acc_q.delete();
        rst = 1'b1;
        #1;
        check("t7_rst_ram_en", 32'(ram_en), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("t7_arready_after", 32'(arready), 32'd1);
        check("t7_rvalid_after", 32'(rvalid), 32'd0);
        step();
        #1;
        check("t7_rvalid_later", 32'(rvalid), 32'd0);
        check("t7_no_access", 32'(acc_q.size()), 32'd0);
        step();

        for (int k = 0; k < 40; k++) begin
            t_size  = 3'($urandom_range(0, 2));
            t_burst = 2'($urandom_range(0, 1));
            t_len   = 8'($urandom_range(0, 15));
            t_addr  = $urandom_range(0, 32'hFFF);
            t_addr  = t_addr & ~((32'd1 << t_size) - 32'd1);
            e = $urandom_range(0, 9);
            if (e == 0) t_size = 3'd3;
            if (e == 1) t_burst = 2'b10;
            if (e == 2) t_addr = t_addr | 32'h0100_0000;
            if ($urandom_range(0, 1) == 0)
                rd_txn(4'($urandom_range(0, 15)), t_addr, t_len, t_size, t_burst, 1'b1);
            else
                wr_txn(4'($urandom_range(0, 15)), t_addr, t_len, t_size, t_burst, 1'b1,
                       (e == 3) ? 0 : -1, e == 4);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
